// File: rtl/cla_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cla_pipe
// Purpose  : Two-stage pipelined carry-lookahead adder/subtractor built from
//            4-bit lookahead groups joined by a flat block-level lookahead.
//            Valid/ready handshake on both sides with full backpressure.
//
// Ports    : clk        rising-edge clock
//            rst_n      asynchronous active-low reset
//            in_valid   operands/mode valid this cycle
//            in_ready   block accepts operands this cycle
//            x, y       operands A and B (WIDTH bits)
//            cin        carry-in, ignored when sub=1
//            sub        0: z = x + y + cin ; 1: z = x - y
//            out_valid  result valid
//            out_ready  consumer accepts result
//            z          sum/difference (WIDTH bits)
//            cout       carry-out of MSB (borrow-not for subtraction)
//            ovf        signed overflow
//
// Options  : CLA_PIPE_SAT_EN - when defined, z saturates to the signed
//            extreme on overflow; cout/ovf still report the raw values.
//
// Revision : 1.0 - initial release
// ============================================================================
module cla_pipe #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             ovf
);

    localparam int c_num_groups = WIDTH / GROUP;

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
            $error("cla_pipe: WIDTH must be a multiple of 4 in the range 4..64");
        end
        if (GROUP != 4) begin : g_bad_group
            $error("cla_pipe: GROUP must be 4");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic                    r_rst_done;
    logic                    r_s1_valid;
    logic [WIDTH-1:0]        r_s1_x;
    logic [WIDTH-1:0]        r_s1_y;
    logic                    r_s1_c0;
    logic [c_num_groups-1:0] r_s1_pg;
    logic [c_num_groups-1:0] r_s1_gg;

    logic                    r_out_valid;
    logic [WIDTH-1:0]        r_z;
    logic                    r_cout;
    logic                    r_ovf;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic w_s2_adv;
    logic w_s1_adv;
    logic w_accept;

    // out_ready may be X while out_valid is low; !0 dominates the OR.
    assign w_s2_adv = ~r_out_valid | out_ready;
    assign w_s1_adv = r_s1_valid & w_s2_adv;
    // r_rst_done keeps the input closed until the first edge after reset
    // release, so an operand is never captured on the release edge itself.
    assign in_ready = r_rst_done & (~r_s1_valid | w_s2_adv);
    assign w_accept = in_valid & in_ready;

    // ------------------------------------------------------------------
    // Stage 1 combinational: operand conditioning and group P/G
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]        w_y_eff;
    logic                    w_c0;
    logic [WIDTH-1:0]        w_p0;
    logic [WIDTH-1:0]        w_g0;
    logic [c_num_groups-1:0] w_pg;
    logic [c_num_groups-1:0] w_gg;

    always_comb begin
        logic v_gacc;
        v_gacc  = 1'b0;
        w_y_eff = sub ? ~y : y;
        w_c0    = sub ? 1'b1 : cin;
        w_p0    = x ^ w_y_eff;
        w_g0    = x & w_y_eff;
        w_pg    = '0;
        w_gg    = '0;
        for (int k = 0; k < c_num_groups; k++) begin
            w_pg[k] = &w_p0[k*GROUP +: GROUP];
            // Iterative form of g3 | p3g2 | p3p2g1 | p3p2p1g0.
            v_gacc = 1'b0;
            for (int b = 0; b < GROUP; b++) begin
                v_gacc = w_g0[k*GROUP+b] | (w_p0[k*GROUP+b] & v_gacc);
            end
            w_gg[k] = v_gacc;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: flat group carries, per-bit sums
    // ------------------------------------------------------------------
    logic [c_num_groups:0] w_gc;
    logic [WIDTH-1:0]      w_sum;
    logic                  w_c_msb;
    logic                  w_cout;
    logic                  w_ovf;
    logic [WIDTH-1:0]      w_z_next;

    always_comb begin
        logic [WIDTH-1:0]      v_p;
        logic [WIDTH-1:0]      v_g;
        logic [c_num_groups:0] v_gc;
        logic                  v_term;
        logic                  v_acc;
        logic                  v_c;

        v_p     = r_s1_x ^ r_s1_y;
        v_g     = r_s1_x & r_s1_y;
        v_gc    = '0;
        v_term  = 1'b0;
        v_acc   = 1'b0;
        v_c     = 1'b0;
        w_sum   = '0;
        w_c_msb = 1'b0;

        // Each group carry is an independent sum of products over the
        // registered group P/G terms and c0, so no carry ripples group to
        // group: c[k+1] = Gg[k] | Pg[k]Gg[k-1] | ... | Pg[k..0]c0.
        v_gc[0] = r_s1_c0;
        for (int k = 0; k < c_num_groups; k++) begin
            v_acc = r_s1_c0;
            for (int m = 0; m <= k; m++) begin
                v_acc = v_acc & r_s1_pg[m];
            end
            for (int j = 0; j <= k; j++) begin
                v_term = r_s1_gg[j];
                for (int m = j + 1; m <= k; m++) begin
                    v_term = v_term & r_s1_pg[m];
                end
                v_acc = v_acc | v_term;
            end
            v_gc[k+1] = v_acc;
        end

        // Bit carries only travel inside one 4-bit group.
        for (int k = 0; k < c_num_groups; k++) begin
            v_c = v_gc[k];
            for (int b = 0; b < GROUP; b++) begin
                w_sum[k*GROUP+b] = v_p[k*GROUP+b] ^ v_c;
                if ((k * GROUP + b) == (WIDTH - 1)) begin
                    w_c_msb = v_c;
                end
                v_c = v_g[k*GROUP+b] | (v_p[k*GROUP+b] & v_c);
            end
        end

        w_gc = v_gc;
    end

    assign w_cout = w_gc[c_num_groups];
    assign w_ovf  = w_cout ^ w_c_msb;

`ifdef CLA_PIPE_SAT_EN
    // Overflow can only occur when both conditioned operands share a sign,
    // so the sign of x selects the extreme.
    always_comb begin
        w_z_next = w_sum;
        if (w_ovf) begin
            w_z_next = r_s1_x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_z_next = w_sum;
`endif

    // ------------------------------------------------------------------
    // Reset-release flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 registers: data is captured only on accept, so X operands
    // presented while idle never enter the pipeline.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_s1_c0    <= 1'b0;
            r_s1_pg    <= '0;
            r_s1_gg    <= '0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_x     <= x;
                r_s1_y     <= w_y_eff;
                r_s1_c0    <= w_c0;
                r_s1_pg    <= w_pg;
                r_s1_gg    <= w_gg;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 registers: held while out_valid & !out_ready
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_z         <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_s2_adv) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_z    <= w_z_next;
                    r_cout <= w_cout;
                    r_ovf  <= w_ovf;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign z         = r_z;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_pipe
// Purpose  : Directed self-checking bench for cla_pipe. Drives a WIDTH=4 and
//            a WIDTH=16 instance with hand-computed vectors, backpressure
//            and mid-stream reset sequences. Honours CLA_PIPE_SAT_EN for
//            the overflow vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_pipe;

`ifdef CLA_PIPE_SAT_EN
    localparam bit c_sat = 1'b1;
`else
    localparam bit c_sat = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // WIDTH=4 instance
    logic       a_in_valid, a_in_ready, a_cin, a_sub;
    logic       a_out_valid, a_out_ready, a_cout, a_ovf;
    logic [3:0] a_x, a_y, a_z;

    // WIDTH=16 instance
    logic        b_in_valid, b_in_ready, b_cin, b_sub;
    logic        b_out_valid, b_out_ready, b_cout, b_ovf;
    logic [15:0] b_x, b_y, b_z;

    int n_cmp = 0;
    int n_err = 0;

    cla_pipe #(.WIDTH(4), .GROUP(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .x         (a_x),
        .y         (a_y),
        .cin       (a_cin),
        .sub       (a_sub),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .z         (a_z),
        .cout      (a_cout),
        .ovf       (a_ovf)
    );

    cla_pipe #(.WIDTH(16), .GROUP(4)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .x         (b_x),
        .y         (b_y),
        .cin       (b_cin),
        .sub       (b_sub),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .z         (b_z),
        .cout      (b_cout),
        .ovf       (b_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One unstalled transaction: accept, then result exactly two edges later.
    task automatic run_op(input bit w16, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic s,
                          input logic [15:0] ez, input logic ec, input logic eo,
                          input string tag);
        if (w16) begin
            b_x = a; b_y = b; b_cin = ci; b_sub = s;
            b_in_valid = 1'b1; b_out_ready = 1'b1;
        end else begin
            a_x = a[3:0]; a_y = b[3:0]; a_cin = ci; a_sub = s;
            a_in_valid = 1'b1; a_out_ready = 1'b1;
        end
        #1;
        chk({tag, " in_ready"}, w16 ? b_in_ready : a_in_ready, 64'd1);
        tick();
        // Operands go X once accepted; they must not matter any more.
        if (w16) begin
            b_in_valid = 1'b0; b_x = 'x; b_y = 'x; b_cin = 'x; b_sub = 'x;
        end else begin
            a_in_valid = 1'b0; a_x = 'x; a_y = 'x; a_cin = 'x; a_sub = 'x;
        end
        chk({tag, " lat1"}, w16 ? b_out_valid : a_out_valid, 64'd0);
        tick();
        chk({tag, " valid"}, w16 ? b_out_valid : a_out_valid, 64'd1);
        chk({tag, " z"},     w16 ? {48'd0, b_z} : {60'd0, a_z}, {48'd0, ez});
        chk({tag, " cout"},  w16 ? b_cout : a_cout, {63'd0, ec});
        chk({tag, " ovf"},   w16 ? b_ovf : a_ovf, {63'd0, eo});
        tick();
        chk({tag, " drain"}, w16 ? b_out_valid : a_out_valid, 64'd0);
    endtask

    task automatic drive16(input logic [15:0] a, input logic [15:0] b);
        b_x = a; b_y = b; b_cin = 1'b0; b_sub = 1'b0; b_in_valid = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_x = '0; a_y = '0; a_cin = 1'b0; a_sub = 1'b0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_x = '0; b_y = '0; b_cin = 1'b0; b_sub = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst a_out_valid", a_out_valid, 64'd0);
        chk("rst a_z",         a_z, 64'd0);
        chk("rst b_out_valid", b_out_valid, 64'd0);
        chk("rst b_z",         b_z, 64'd0);
        chk("rst b_cout",      b_cout, 64'd0);
        chk("rst b_ovf",       b_ovf, 64'd0);

        rst_n = 1'b1;
        tick();
        chk("post-rst a_in_ready", a_in_ready, 64'd1);
        chk("post-rst b_in_ready", b_in_ready, 64'd1);

        // WIDTH=4 vectors
        run_op(1'b0, 16'h1, 16'h2, 1'b0, 1'b0, 16'h3, 1'b0, 1'b0, "w4 1+2");
        run_op(1'b0, 16'hF, 16'hF, 1'b0, 1'b0, 16'hE, 1'b1, 1'b0, "w4 F+F");
        run_op(1'b0, 16'h7, 16'h1, 1'b0, 1'b0, c_sat ? 16'h7 : 16'h8, 1'b0, 1'b1, "w4 7+1 ovf");
        run_op(1'b0, 16'h3, 16'h5, 1'b0, 1'b1, 16'hE, 1'b0, 1'b0, "w4 3-5");
        run_op(1'b0, 16'h8, 16'h1, 1'b0, 1'b1, c_sat ? 16'h8 : 16'h7, 1'b1, 1'b1, "w4 8-1 ovf");

        // WIDTH=16 vectors
        run_op(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "w16 FFFF+0+1");
        run_op(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, c_sat ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1, "w16 8000-1");
        run_op(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "w16 1234+4321");
        run_op(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, c_sat ? 16'h7FFF : 16'h8000, 1'b0, 1'b1, "w16 7FFF+1");
        run_op(1'b1, 16'h0005, 16'h0005, 1'bx, 1'b1, 16'h0000, 1'b1, 1'b0, "w16 5-5 cinX");
        run_op(1'b1, 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, "w16 0F0F+00F1");
        run_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "w16 FFFF+1");

        // Backpressure: op k is 0x10*k + k -> 0x11*k
        b_out_ready = 1'b0;
        drive16(16'h0010, 16'h0001);
        #1; chk("bp t0 in_ready", b_in_ready, 64'd1);
        tick();
        drive16(16'h0020, 16'h0002);
        #1; chk("bp t1 in_ready", b_in_ready, 64'd1);
        chk("bp t1 out_valid", b_out_valid, 64'd0);
        tick();
        drive16(16'h0030, 16'h0003);
        #1; chk("bp t2 out_valid", b_out_valid, 64'd1);
        chk("bp t2 z", b_z, 64'h0011);
        chk("bp t2 in_ready", b_in_ready, 64'd0);
        tick();
        // Operands changed while stalled must have no effect.
        b_x = 16'hDEAD; b_y = 16'hBEEF;
        #1; chk("bp t3 z held", b_z, 64'h0011);
        chk("bp t3 in_ready", b_in_ready, 64'd0);
        tick();
        drive16(16'h0030, 16'h0003);
        #1; chk("bp t4 z held", b_z, 64'h0011);
        chk("bp t4 out_valid", b_out_valid, 64'd1);
        b_out_ready = 1'b1;
        #1; chk("bp t4 in_ready comb", b_in_ready, 64'd1);
        tick();
        drive16(16'h0040, 16'h0004);
        #1; chk("bp t5 valid", b_out_valid, 64'd1);
        chk("bp t5 z", b_z, 64'h0022);
        tick();
        drive16(16'h0050, 16'h0005);
        #1; chk("bp t6 valid", b_out_valid, 64'd1);
        chk("bp t6 z", b_z, 64'h0033);
        tick();
        b_in_valid = 1'b0;
        #1; chk("bp t7 valid", b_out_valid, 64'd1);
        chk("bp t7 z", b_z, 64'h0044);
        tick();
        chk("bp t8 valid", b_out_valid, 64'd1);
        chk("bp t8 z", b_z, 64'h0055);
        tick();
        chk("bp t9 empty", b_out_valid, 64'd0);

        // Reset with both stages full
        b_out_ready = 1'b0;
        drive16(16'h1111, 16'h1111);
        tick();
        drive16(16'h3333, 16'h1111);
        tick();
        b_in_valid = 1'b0;
        chk("mrst full valid", b_out_valid, 64'd1);
        chk("mrst full z", b_z, 64'h2222);
        chk("mrst full in_ready", b_in_ready, 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst async out_valid", b_out_valid, 64'd0);
        chk("mrst async z", b_z, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        b_out_ready = 1'b1;
        tick();
        chk("mrst no stale 1", b_out_valid, 64'd0);
        chk("mrst in_ready", b_in_ready, 64'd1);
        tick();
        chk("mrst no stale 2", b_out_valid, 64'd0);
        run_op(1'b1, 16'h0100, 16'h0200, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0, "mrst first op");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
